clk_divider_multi: RTL and testbench

- NUM_CH independent programmable clock dividers sharing one source clock clk_in; each channel has its own divisor and high-time (duty) setting.
- Each channel has glitch-free settings update at period boundaries, graceful enable/disable, and a per-channel period-start tick.
- A global sync input phase-aligns all channels.
- Feeds peripheral clock enables and slow strobes inside the wrapped user project.

---
 rtl/clk_divider_multi.sv | 156 +++++++++++++++
 tb/tb_clk_divider_multi.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// clk_divider_multi
//   NUM_CH independent programmable clock dividers running from clk_in.
//   Each channel has a period (divisor) and a high time (0 = 50% duty).
//   New settings are captured into a shadow register by an update strobe.
//   They take effect only at a period boundary, or on a sync or while idle,
//   so a period is never cut short and never stretched.
//   A shared sync input restarts every running channel at period start.
//
// Ports
//   clk_in     source clock, rising edge
//   rst        synchronous, active-high reset
//   ch_en      per-channel run enable; a disable lets the current period finish
//   divisor    per-channel period in clk_in cycles, slice [i*DIV_W +: DIV_W]
//   high_time  per-channel high cycles, same slicing; 0 selects 50% duty
//   update     per-channel strobe that captures divisor/high_time into the shadow
//   sync       restarts all running channels at cnt=0
//   clk_out    divided clock outputs (registered)
//   tick       one-cycle pulse on the first cycle of each period (registered)
//   pending    shadow captured but not yet applied
//
// Per-channel run state
//   state   | meaning
//   idle    | run=0, outputs low; applies a pending shadow, starts when enabled and D!=0
//   running | counting cnt 0..De-1; wrap/sync may apply the shadow, restart or stop

module clk_divider_multi #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] divisor,
    input  logic [NUM_CH*DIV_W-1:0] high_time,
    input  logic [NUM_CH-1:0]       update,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    // A divisor of 1 cannot toggle, so it is treated as a period of 2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == DIV_W'(1)) ? DIV_W'(2) : d;
    endfunction

    // The high time is clamped to De-1 so the output always returns low.
    function automatic logic [DIV_W-1:0] eff_high(input logic [DIV_W-1:0] d,
                                                  input logic [DIV_W-1:0] h);
        logic [DIV_W-1:0] de;
        de = eff_div(d);
        if (h == '0)
            return de >> 1;
        else if (h >= de)
            return de - DIV_W'(1);
        else
            return h;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] act_d, act_h, sh_d, sh_h, cnt;
        logic             pend_q, run_q, clk_q, tick_q;
        logic [DIV_W-1:0] act_d_n, act_h_n, sh_d_n, sh_h_n, cnt_n;
        logic             pend_n, run_n, clk_n, tick_n;
        logic [DIV_W-1:0] use_d, use_h, he, cnt_inc;
        logic             wrap, apply, stop;

        // State register
        always_ff @(posedge clk_in) begin
            if (rst) begin
                act_d  <= '0;
                act_h  <= '0;
                sh_d   <= '0;
                sh_h   <= '0;
                cnt    <= '0;
                pend_q <= 1'b0;
                run_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                act_d  <= act_d_n;
                act_h  <= act_h_n;
                sh_d   <= sh_d_n;
                sh_h   <= sh_h_n;
                cnt    <= cnt_n;
                pend_q <= pend_n;
                run_q  <= run_n;
                clk_q  <= clk_n;
                tick_q <= tick_n;
            end
        end

        // Next-state logic
        always_comb begin
            act_d_n = act_d;
            act_h_n = act_h;
            sh_d_n  = sh_d;
            sh_h_n  = sh_h;
            pend_n  = pend_q;
            run_n   = run_q;
            cnt_n   = cnt;
            clk_n   = clk_q;
            tick_n  = 1'b0;
            cnt_inc = cnt + DIV_W'(1);
            wrap    = run_q && (cnt == eff_div(act_d) - DIV_W'(1));
            // The shadow is applied while idle, at a wrap, or on sync.
            apply   = pend_q && (!run_q || wrap || sync);
            use_d   = apply ? sh_d : act_d;
            use_h   = apply ? sh_h : act_h;
            he      = eff_high(use_d, use_h);
            // Sync keeps a running channel running unless it has been set to D=0.
            stop    = (use_d == '0) || (!sync && !ch_en[g]);

            if (apply) begin
                act_d_n = sh_d;
                act_h_n = sh_h;
                pend_n  = 1'b0;
            end
            // A strobe lands after any apply this cycle, so it is never applied in its own cycle.
            if (update[g]) begin
                sh_d_n = divisor[g*DIV_W +: DIV_W];
                sh_h_n = high_time[g*DIV_W +: DIV_W];
                pend_n = 1'b1;
            end

            if (!run_q) begin
                cnt_n = '0;
                clk_n = 1'b0;
                // Start only once nothing is waiting to be applied.
                if (!pend_q && ch_en[g] && (act_d != '0)) begin
                    run_n  = 1'b1;
                    clk_n  = (eff_high(act_d, act_h) != '0);
                    tick_n = 1'b1;
                end
            end else if (sync || wrap) begin
                cnt_n = '0;
                if (stop) begin
                    run_n = 1'b0;
                    clk_n = 1'b0;
                end else begin
                    clk_n  = (he != '0);
                    tick_n = 1'b1;
                end
            end else begin
                cnt_n = cnt_inc;
                clk_n = (cnt_inc < he);
            end
        end

        // Outputs
        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
module tb_clk_divider_multi;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic                    clk_in = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] divisor;
    logic [NUM_CH*DIV_W-1:0] high_time;
    logic [NUM_CH-1:0]       update;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;

    clk_divider_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .ch_en     (ch_en),
        .divisor   (divisor),
        .high_time (high_time),
        .update    (update),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;

    // kind 0: {clk_out, tick}; kind 1: pending
    typedef struct {
        int    cyc;
        int    kind;
        int    ch;
        logic  a;
        logic  b;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic push(input int off, input int kind, input int ch,
                        input logic a, input logic b, input string tag);
        exp_t e;
        e.cyc = cyc + off; e.kind = kind; e.ch = ch; e.a = a; e.b = b; e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected waveform of a running channel: period de, high he, starting at cnt=ph.
    task automatic pattern(input int ch, input int off, input int de, input int he,
                           input int ph, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ph + k) % de;
            push(off + k, 0, ch, (c < he), (c == 0), tag);
        end
    endtask

    task automatic idle(input int ch, input int from, input int to, input string tag);
        for (int k = from; k <= to; k++) push(k, 0, ch, 1'b0, 1'b0, tag);
    endtask

    task automatic pend(input int ch, input int off, input logic v, input string tag);
        push(off, 1, ch, v, 1'b0, tag);
    endtask

    task automatic check(input exp_t e);
        logic [1:0] obs, exp;
        if (e.kind == 0) begin
            obs = {clk_out[e.ch], tick[e.ch]};
            exp = {e.a, e.b};
        end else begin
            obs = {1'b0, pending[e.ch]};
            exp = {1'b0, e.a};
        end
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s ch%0d cyc%0d kind%0d: got %b expected %b",
                   e.tag, e.ch, cyc, e.kind, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                exp_t e;
                e = sb[i];
                sb.delete(i);
                check(e);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_ch(input int ch, input int d, input int h, input logic en);
        divisor[ch*DIV_W +: DIV_W]   = DIV_W'(d);
        high_time[ch*DIV_W +: DIV_W] = DIV_W'(h);
        ch_en[ch]  = en;
        update[ch] = 1'b1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ch_en  = '0;
        update = '0;
        sync   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            push(1, 0, c, 1'b0, 1'b0, "reset_out");
            pend(c, 1, 1'b0, "reset_pend");
        end
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ch_en     = '0;
        divisor   = '0;
        high_time = '0;
        update    = '0;
        sync      = 1'b0;
        #1;

        // D=4 H=0: start after one pending cycle, 1100 pattern, tick with first high cycle
        do_reset();
        set_ch(0, 4, 0, 1'b1);
        pend(0, 1, 1'b1, "a_pend");
        pend(0, 2, 1'b0, "a_pend_clr");
        idle(0, 1, 2, "a_idle");
        pattern(0, 3, 4, 2, 0, 12, "a_d4");
        cycle();
        update = '0;
        run(13);

        // Mid-period update to D=6 H=2: current period finishes, live inputs ignored
        pattern(0, 1, 4, 2, 0, 4, "b_old");
        cycle();
        set_ch(0, 6, 2, 1'b1);
        pend(0, 1, 1'b1, "b_pend");
        pend(0, 2, 1'b1, "b_pend");
        pend(0, 3, 1'b1, "b_pend");
        pend(0, 4, 1'b0, "b_pend_clr");
        pattern(0, 4, 6, 2, 0, 12, "b_d6");
        cycle();
        update = '0;
        divisor[0 +: DIV_W]   = DIV_W'(3);
        high_time[0 +: DIV_W] = DIV_W'(1);
        run(14);

        // Duty variants: H=1, clamped H=9, D=1 -> period 2
        do_reset();
        set_ch(0, 5, 1, 1'b1);
        set_ch(1, 5, 9, 1'b1);
        set_ch(2, 1, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            pend(c, 1, 1'b1, "c_pend");
            pend(c, 2, 1'b0, "c_pend_clr");
            idle(c, 1, 2, "c_idle");
        end
        idle(3, 1, 12, "c_ch3_idle");
        pattern(0, 3, 5, 1, 0, 10, "c_h1");
        pattern(1, 3, 5, 4, 0, 10, "c_h9");
        pattern(2, 3, 2, 1, 0, 8, "c_d1");
        cycle();
        update = '0;
        run(12);

        // Drop enable mid high phase (D=8 H=4), then re-enable
        do_reset();
        set_ch(0, 8, 4, 1'b1);
        pend(0, 1, 1'b1, "d_pend");
        pend(0, 2, 1'b0, "d_pend_clr");
        idle(0, 1, 2, "d_idle");
        pattern(0, 3, 8, 4, 0, 8, "d_period");
        cycle();
        update = '0;
        run(3);
        ch_en[0] = 1'b0;
        idle(0, 7, 10, "d_stopped");
        run(10);
        ch_en[0] = 1'b1;
        pattern(0, 1, 8, 4, 0, 8, "d_restart");
        run(8);

        // Sync: ch0 D=3, ch1 D=7 running, ch2 configured but disabled
        do_reset();
        set_ch(0, 3, 0, 1'b1);
        set_ch(1, 7, 0, 1'b1);
        set_ch(2, 5, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            pend(c, 1, 1'b1, "e_pend");
            pend(c, 2, 1'b0, "e_pend_clr");
        end
        idle(0, 1, 2, "e_idle");
        idle(1, 1, 2, "e_idle");
        idle(2, 1, 15, "e_ch2_idle");
        pattern(0, 3, 3, 1, 0, 5, "e_ch0");
        pattern(1, 3, 7, 3, 0, 5, "e_ch1");
        cycle();
        update = '0;
        run(6);
        sync = 1'b1;
        pattern(0, 1, 3, 1, 0, 6, "e_sync_ch0");
        pattern(1, 1, 7, 3, 0, 8, "e_sync_ch1");
        cycle();
        sync = 1'b0;
        run(7);
        pattern(0, 1, 3, 1, 2, 1, "e_pre_wrap");
        pattern(1, 1, 7, 3, 1, 1, "e_pre_wrap");
        cycle();
        sync = 1'b1;
        pattern(0, 1, 3, 1, 0, 6, "e_sync_wrap_ch0");
        pattern(1, 1, 7, 3, 0, 7, "e_sync_wrap_ch1");
        cycle();
        sync = 1'b0;
        run(6);

        // Reset mid-period with an update pending; afterwards D=0 keeps ch0 idle
        set_ch(0, 9, 0, 1'b1);
        pend(0, 1, 1'b1, "f_pend");
        cycle();
        update = '0;
        do_reset();
        ch_en[0] = 1'b1;
        idle(0, 1, 5, "f_idle_d0");
        for (int k = 1; k <= 5; k++) pend(0, k, 1'b0, "f_pend_zero");
        run(5);

        total++;
        assert (sb.size() == 0) passed++;
        else begin
            failed++;
            $error("FAIL leftover_expectations: got %0d entries expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
